psram_arbiter: RTL and testbench

- Shares the single byte-wide PSRAM memory controller between three requesters: ROM loader (write-only), CPU (read/write) and PPU (read-only).
- Sits between the NES core / game loader and the memory controller. Replaces the ad-hoc OR-ing of strobes and address muxing at top level.
- Sequences one transaction at a time: grant, one-cycle issue strobe, completion tracking via the controller's busy signal.
- Returns read data and a one-cycle done pulse to the granted requester.

---
 rtl/psram_pkg.sv | 18 +
 rtl/psram_arbiter_if.sv | 41 ++++
 rtl/psram_rr_pick.sv | 18 +
 rtl/psram_arbiter.sv | 110 +++++++++++
 tb/tb_psram_arbiter.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/psram_pkg.sv
// psram_pkg: shared grant ids, FSM encoding and controller widths for the PSRAM arbiter
package psram_pkg;
   localparam int MC_ADDR_W = 24;
   typedef enum logic [1:0] {
      GNT_LDR = 2'd0,
      GNT_CPU = 2'd1,
      GNT_PPU = 2'd2
   } gnt_t;
   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_BUSY,
      WAIT_DONE
   } state_t;
   function automatic logic [2:0] gnt_onehot(input gnt_t g);
      return 3'b001 << g;
   endfunction
endpackage

// File: rtl/psram_arbiter_if.sv
// psram_arbiter_if: requester-side and controller-side signals of the PSRAM arbiter
interface psram_arbiter_if #(parameter int ADDR_W = 22);
   import psram_pkg::*;
   logic              ldr_req;
   logic [ADDR_W-1:0] ldr_addr;
   logic [7:0]        ldr_wdata;
   logic              ldr_done;
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [7:0]        cpu_wdata;
   logic [7:0]        cpu_rdata;
   logic              cpu_done;
   logic              ppu_req;
   logic [ADDR_W-1:0] ppu_addr;
   logic [7:0]        ppu_rdata;
   logic              ppu_done;
   logic                 mc_read;
   logic                 mc_write;
   logic [MC_ADDR_W-1:0] mc_addr;
   logic [7:0]           mc_din;
   logic                 mc_busy;
   logic [7:0]           mc_dout;
   logic                 timeout_err;
   modport slave (
      input  ldr_req, ldr_addr, ldr_wdata,
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  ppu_req, ppu_addr,
      input  mc_busy, mc_dout,
      output ldr_done, cpu_rdata, cpu_done, ppu_rdata, ppu_done,
      output mc_read, mc_write, mc_addr, mc_din, timeout_err
   );
   modport master (
      output ldr_req, ldr_addr, ldr_wdata,
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output ppu_req, ppu_addr,
      output mc_busy, mc_dout,
      input  ldr_done, cpu_rdata, cpu_done, ppu_rdata, ppu_done,
      input  mc_read, mc_write, mc_addr, mc_din, timeout_err
   );
endinterface

// File: rtl/psram_rr_pick.sv
// psram_rr_pick: loader-first priority with CPU/PPU round-robin against the last CPU/PPU grant
module psram_rr_pick
   import psram_pkg::*;
(
   input  logic ldr_req,
   input  logic cpu_req,
   input  logic ppu_req,
   input  gnt_t rr_last,
   output logic valid,
   output gnt_t gnt
);
   always_comb begin
      valid = ldr_req | cpu_req | ppu_req;
      gnt = ldr_req ? GNT_LDR :
            (cpu_req && ppu_req) ? (rr_last == GNT_CPU ? GNT_PPU : GNT_CPU) :
            cpu_req ? GNT_CPU : GNT_PPU;
   end
endmodule

// File: rtl/psram_arbiter.sv
// psram_arbiter: one-at-a-time sharing of the byte-wide PSRAM controller between loader, CPU and PPU
module psram_arbiter
   import psram_pkg::*;
#(
   parameter int ADDR_W  = 22,
   parameter int TIMEOUT = 15,
   parameter int TO_W    = 4
) (
   input logic clk,
   input logic reset,
   psram_arbiter_if.slave bus
);
   state_t            state, state_n;
   gnt_t              gnt_q, rr_last, pick;
   logic              pick_v;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        wdata_q, cpu_rd_q, ppu_rd_q;
   logic [2:0]        done_q;
   logic [TO_W-1:0]   cnt;
   logic              err_q;
   logic              take, fin_set, cap, to_set, expired, fin;

   psram_rr_pick u_pick (
      .ldr_req (bus.ldr_req),
      .cpu_req (bus.cpu_req),
      .ppu_req (bus.ppu_req),
      .rr_last (rr_last),
      .valid   (pick_v),
      .gnt     (pick)
   );

   assign expired = cnt >= TO_W'(TIMEOUT);
   // done_q is the completion pulse; the FSM lingers in its wait state during it so IDLE starts a cycle later
   assign fin = |done_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= (state_n != state) ? '0 : cnt + TO_W'(1);
      end
   end

   always_comb begin
      state_n = state;
      take    = 1'b0;
      fin_set = 1'b0;
      cap     = 1'b0;
      to_set  = 1'b0;
      case (state)
         IDLE: begin
            take    = pick_v && !bus.mc_busy;
            state_n = take ? ISSUE : IDLE;
         end
         ISSUE: state_n = WAIT_BUSY;
         WAIT_BUSY: begin
            state_n = fin ? IDLE : bus.mc_busy ? WAIT_DONE : WAIT_BUSY;
            to_set  = !fin && !bus.mc_busy && expired;
            fin_set = to_set;
         end
         WAIT_DONE: begin
            state_n = fin ? IDLE : WAIT_DONE;
            cap     = !fin && !bus.mc_busy && !we_q;
            to_set  = !fin && bus.mc_busy && expired;
            fin_set = !fin && (!bus.mc_busy || expired);
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         gnt_q    <= GNT_LDR;
         rr_last  <= GNT_PPU;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= 8'h00;
         cpu_rd_q <= 8'h00;
         ppu_rd_q <= 8'h00;
         done_q   <= 3'b000;
         err_q    <= 1'b0;
      end else begin
         if (take) begin
            gnt_q   <= pick;
            rr_last <= (pick == GNT_LDR) ? rr_last : pick;
            we_q    <= (pick == GNT_LDR) || (pick == GNT_CPU && bus.cpu_we);
            addr_q  <= (pick == GNT_LDR) ? bus.ldr_addr : (pick == GNT_CPU) ? bus.cpu_addr : bus.ppu_addr;
            wdata_q <= (pick == GNT_LDR) ? bus.ldr_wdata : (pick == GNT_CPU) ? bus.cpu_wdata : 8'h00;
         end
         if (cap && gnt_q == GNT_CPU) cpu_rd_q <= bus.mc_dout;
         if (cap && gnt_q == GNT_PPU) ppu_rd_q <= bus.mc_dout;
         done_q <= fin_set ? gnt_onehot(gnt_q) : 3'b000;
         err_q  <= err_q | to_set;
      end
   end

   assign bus.mc_read     = (state == ISSUE) && !we_q;
   assign bus.mc_write    = (state == ISSUE) && we_q;
   assign bus.mc_addr     = {{(MC_ADDR_W-ADDR_W){1'b0}}, addr_q};
   assign bus.mc_din      = wdata_q;
   assign bus.ldr_done    = done_q[0];
   assign bus.cpu_done    = done_q[1];
   assign bus.ppu_done    = done_q[2];
   assign bus.cpu_rdata   = cpu_rd_q;
   assign bus.ppu_rdata   = ppu_rd_q;
   assign bus.timeout_err = err_q;
endmodule

// File: tb/tb_psram_arbiter.sv
// tb_psram_arbiter: scoreboard bench with a busy-for-3-cycles controller model
module tb_psram_arbiter;
   import psram_pkg::*;
   localparam int TIMEOUT = 15;

   typedef struct {
      int         id;
      logic       we;
      logic [21:0] addr;
      logic [7:0] wdata;
      logic [7:0] rdata;
      int         lat;
   } xact_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   bcnt = 0;
   logic busy_en = 1'b1;
   xact_t sb[$];
   xact_t pend;
   logic  pend_v = 1'b0;
   int    t_strobe = 0;
   logic [7:0] last_rd [3];
   logic [2:0] dn;

   psram_arbiter_if #(.ADDR_W(22)) bus ();
   psram_arbiter #(.ADDR_W(22), .TIMEOUT(TIMEOUT), .TO_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] mem_val(input logic [23:0] a);
      return (a == 24'h001234) ? 8'hA5 : (a[7:0] ^ a[15:8] ^ 8'h3C);
   endfunction

   always @(posedge clk)
      if ((bus.mc_read || bus.mc_write) && busy_en) bcnt <= 3;
      else if (bcnt != 0) bcnt <= bcnt - 1;
   assign bus.mc_busy = bcnt != 0;
   assign bus.mc_dout = mem_val(bus.mc_addr);
   assign dn = {bus.ppu_done, bus.cpu_done, bus.ldr_done};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic void push(input int id, input logic we, input logic [21:0] a, input logic [7:0] d, input logic to);
      xact_t x;
      x.id = id;
      x.we = we;
      x.addr = a;
      x.wdata = d;
      x.rdata = we ? 8'h00 : to ? last_rd[id] : mem_val({2'b00, a});
      x.lat = to ? TIMEOUT + 2 : 5;
      if (!we) last_rd[id] = x.rdata;
      sb.push_back(x);
   endfunction

   // strobes are matched to the scoreboard head, done pulses to the outstanding strobe
   always @(negedge clk) begin
      if (reset) pend_v = 1'b0;
      else begin
         if (bus.mc_read || bus.mc_write) begin
            check("overlap", 32'(pend_v), 32'(0));
            check("strobe_expected", 32'(sb.size() != 0), 32'(1));
            if (sb.size() != 0) begin
               pend = sb.pop_front();
               pend_v = 1'b1;
               t_strobe = cyc;
               check("strobe_we", 32'(bus.mc_write), 32'(pend.we));
               check("strobe_rd", 32'(bus.mc_read), 32'(!pend.we));
               check("mc_addr", 32'(bus.mc_addr), 32'(pend.addr));
               if (pend.we) check("mc_din", 32'(bus.mc_din), 32'(pend.wdata));
            end
         end
         if (dn != 3'b000) begin
            check("done_pending", 32'(pend_v), 32'(1));
            if (pend_v) begin
               check("done_id", 32'(dn), 32'(3'b001 << pend.id));
               check("latency", cyc - t_strobe, pend.lat);
               if (!pend.we)
                  check("rdata", 32'(pend.id == 1 ? bus.cpu_rdata : bus.ppu_rdata), 32'(pend.rdata));
               pend_v = 1'b0;
            end
         end
      end
   end

   task automatic wait_done(input logic [2:0] mask, input int lim = 40);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((dn & mask) == 3'b000 && n < lim);
      check("done_seen", 32'((dn & mask) != 3'b000), 32'(1));
   endtask

   task automatic wait_strobe(input int lim = 40);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(bus.mc_read || bus.mc_write) && n < lim);
      check("strobe_seen", 32'(bus.mc_read || bus.mc_write), 32'(1));
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_mc_read"}, 32'(bus.mc_read), 32'(0));
      check({tag, "_mc_write"}, 32'(bus.mc_write), 32'(0));
      check({tag, "_done"}, 32'(dn), 32'(0));
      check({tag, "_timeout_err"}, 32'(bus.timeout_err), 32'(0));
      check({tag, "_cpu_rdata"}, 32'(bus.cpu_rdata), 32'(0));
      check({tag, "_ppu_rdata"}, 32'(bus.ppu_rdata), 32'(0));
      check({tag, "_mc_addr"}, 32'(bus.mc_addr), 32'(0));
      check({tag, "_mc_din"}, 32'(bus.mc_din), 32'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int cn, pn;
      last_rd = '{8'h00, 8'h00, 8'h00};
      bus.ldr_req = 0; bus.ldr_addr = 0; bus.ldr_wdata = 0;
      bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
      bus.ppu_req = 0; bus.ppu_addr = 0;
      repeat (3) @(negedge clk);
      check_reset("rst");
      reset = 0;

      push(GNT_CPU, 1'b0, 22'h001234, 8'h00, 1'b0);
      bus.cpu_addr = 22'h001234; bus.cpu_req = 1;
      wait_done(3'b010);
      bus.cpu_req = 0;
      @(negedge clk);
      check("t1_pulse_width", 32'(dn), 32'(0));
      check("t1_cpu_rdata", 32'(bus.cpu_rdata), 32'h A5);

      push(GNT_PPU, 1'b0, 22'h3ABCDE, 8'h00, 1'b0);
      bus.ppu_addr = 22'h3ABCDE; bus.ppu_req = 1;
      wait_done(3'b100);
      bus.ppu_req = 0;

      push(GNT_CPU, 1'b0, 22'h000010, 8'h00, 1'b0);
      push(GNT_PPU, 1'b0, 22'h000020, 8'h00, 1'b0);
      push(GNT_CPU, 1'b0, 22'h000011, 8'h00, 1'b0);
      push(GNT_PPU, 1'b0, 22'h000021, 8'h00, 1'b0);
      bus.cpu_addr = 22'h000010; bus.ppu_addr = 22'h000020;
      bus.cpu_req = 1; bus.ppu_req = 1;
      cn = 0; pn = 0;
      repeat (4) begin
         wait_done(3'b110);
         if (bus.cpu_done) begin
            cn++;
            bus.cpu_addr = 22'h000011;
            if (cn == 2) bus.cpu_req = 0;
         end
         if (bus.ppu_done) begin
            pn++;
            bus.ppu_addr = 22'h000021;
            if (pn == 2) bus.ppu_req = 0;
         end
      end

      push(GNT_CPU, 1'b0, 22'h000100, 8'h00, 1'b0);
      bus.cpu_addr = 22'h000100; bus.cpu_req = 1;
      wait_strobe();
      bus.ppu_addr = 22'h000200; bus.ppu_req = 1;
      repeat (2) @(negedge clk);
      push(GNT_LDR, 1'b1, 22'h000300, 8'h5C, 1'b0);
      push(GNT_PPU, 1'b0, 22'h000200, 8'h00, 1'b0);
      bus.ldr_addr = 22'h000300; bus.ldr_wdata = 8'h5C; bus.ldr_req = 1;
      wait_done(3'b010);
      bus.cpu_req = 0;
      wait_done(3'b001);
      bus.ldr_req = 0;
      wait_done(3'b100);
      bus.ppu_req = 0;

      check("t4_err_before", 32'(bus.timeout_err), 32'(0));
      busy_en = 0;
      push(GNT_PPU, 1'b0, 22'h000444, 8'h00, 1'b1);
      bus.ppu_addr = 22'h000444; bus.ppu_req = 1;
      wait_done(3'b100, 60);
      bus.ppu_req = 0;
      busy_en = 1;
      check("t4_err_set", 32'(bus.timeout_err), 32'(1));
      repeat (5) @(negedge clk);
      check("t4_err_sticky", 32'(bus.timeout_err), 32'(1));

      push(GNT_CPU, 1'b1, 22'h000555, 8'h77, 1'b0);
      bus.cpu_we = 1; bus.cpu_addr = 22'h000555; bus.cpu_wdata = 8'h77; bus.cpu_req = 1;
      wait_strobe();
      bus.cpu_req = 0;
      wait_done(3'b010);
      repeat (10) @(negedge clk);
      check("t5_sb_empty", sb.size(), 0);
      check("t5_no_pending", 32'(pend_v), 32'(0));

      push(GNT_CPU, 1'b0, 22'h000666, 8'h00, 1'b0);
      bus.cpu_we = 0; bus.cpu_addr = 22'h000666; bus.cpu_req = 1;
      wait_strobe();
      repeat (2) @(negedge clk);
      reset = 1;
      bus.cpu_req = 0;
      @(negedge clk);
      check_reset("abort");
      reset = 0;
      last_rd = '{8'h00, 8'h00, 8'h00};
      repeat (8) begin
         @(negedge clk);
         check("t6_quiet", 32'(dn), 32'(0));
      end

      push(GNT_CPU, 1'b0, 22'h000777, 8'h00, 1'b0);
      push(GNT_PPU, 1'b0, 22'h000888, 8'h00, 1'b0);
      bus.cpu_addr = 22'h000777; bus.ppu_addr = 22'h000888;
      bus.cpu_req = 1; bus.ppu_req = 1;
      repeat (2) begin
         wait_done(3'b110);
         if (bus.cpu_done) bus.cpu_req = 0;
         if (bus.ppu_done) bus.ppu_req = 0;
      end
      repeat (4) @(negedge clk);
      check("final_sb_empty", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
